master_if: RTL

MASTER_IF -- requirements
Module: master_if

---
 rtl/master_if.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/master_if.sv
// Crossbar master port adapter: captures one upstream request, routes it to one of
// four slave ports chosen by the top address bits, and returns ack/data or a timeout.
module master_if #(
  parameter int unsigned CMD_W  = 1,
  parameter int unsigned AW     = 12,
  parameter int unsigned DW     = 32,
  parameter int unsigned SW     = 4,
  parameter int unsigned TO_CYC = 64
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iMstReq,
  input  logic [CMD_W-1:0]  iMstCmd,
  input  logic [AW-1:0]     iMstAddr,
  input  logic [SW-1:0]     iMstSel,
  input  logic [DW-1:0]     iMstWData,
  output logic              oMstAck,
  output logic              oMstErr,
  output logic [DW-1:0]     oMstRData,
  output logic [3:0]        oSlvReq,
  output logic [CMD_W-1:0]  oSlvCmd,
  output logic [AW-1:0]     oSlvAddr,
  output logic [SW-1:0]     oSlvSel,
  output logic [DW-1:0]     oSlvWData,
  input  logic [3:0]        iSlvAck,
  input  logic [4*DW-1:0]   iSlvRData
);

  localparam int unsigned NPORT = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    REL  = 2'd3
  } state_t;

  // Request payload broadcast to every slave port
  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [AW-1:0]    addr;
    logic [SW-1:0]    sel;
    logic [DW-1:0]    wdata;
  } slv_bus_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     port_q, port_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NPORT-1:0]  slv_req_q, slv_req_d;
  slv_bus_t          bus_q, bus_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic [DW-1:0]     slv_rdata [NPORT];
  logic              sel_ack_c;
  logic [PW-1:0]     mst_port_c;

  // Split the flat slave read-data bus into per-port words
  for (genvar p = 0; p < NPORT; p++) begin : g_rdata
    assign slv_rdata[p] = iSlvRData[p*DW +: DW];
  end

  assign sel_ack_c  = iSlvAck[port_q];
  assign mst_port_c = iMstAddr[AW-1 -: PW];

  // State and output registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      port_q    <= '0;
      cnt_q     <= '0;
      slv_req_q <= '0;
      bus_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      cnt_q     <= cnt_d;
      slv_req_q <= slv_req_d;
      bus_q     <= bus_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    cnt_d     = cnt_q;
    slv_req_d = slv_req_q;
    bus_d     = bus_q;
    ack_d     = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (iMstReq) begin
          bus_d.cmd   = iMstCmd;
          bus_d.addr  = iMstAddr;
          bus_d.sel   = iMstSel;
          bus_d.wdata = iMstWData;
          port_d      = mst_port_c;
          slv_req_d   = NPORT'(1) << mst_port_c;
          cnt_d       = '0;
          state_d     = REQ;
        end
      end

      REQ: begin
        // Ack is checked first so it wins over a timeout on the same edge
        if (sel_ack_c) begin
          rdata_d   = slv_rdata[port_q];
          err_d     = 1'b0;
          ack_d     = 1'b1;
          slv_req_d = '0;
          state_d   = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          ack_d     = 1'b1;
          slv_req_d = '0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d = REL;
      end

      REL: begin
        // Master must drop its request before a new one is accepted
        if (!iMstReq) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign oMstAck   = ack_q;
  assign oMstErr   = err_q;
  assign oMstRData = rdata_q;
  assign oSlvReq   = slv_req_q;
  assign oSlvCmd   = bus_q.cmd;
  assign oSlvAddr  = bus_q.addr;
  assign oSlvSel   = bus_q.sel;
  assign oSlvWData = bus_q.wdata;

endmodule
